sincos_seq: RTL and testbench
=============================

// Module: sincos_seq
// PURPOSE
//  Time-multiplexed sine/cosine engine for the rotor model (Park/inverse-Park angles).
//  Computes sin and cos of one angle with a single shared qmult_SN and a single qadd_SN.
//  Uses the 7th-order odd polynomial in y = x*2/pi, with range reduction from [-pi, pi] to [0, pi/2].
//  Start/complete handshake matches qdiv_SN, so the block drops in beside the divider.
// PARAMETERS
//  Q  12  fractional bits (sign-magnitude fixed point)
//  N  24  word width; bit N-1 is the sign, bits N-2:0 are the magnitude
// PORTS
//  i_clk       in   1  clock, rising edge
//  i_rst_n     in   1  asynchronous, active-low reset
//  i_start     in   1  request; sampled only while o_complete=1
//  i_angle     in   N  angle in radians, sign-magnitude Q12
//  o_sin       out  N  sin(i_angle), sign-magnitude Q12
//  o_cos       out  N  cos(i_angle), sign-magnitude Q12
//  o_complete  out  1  1 = idle, results valid; 0 = busy
//  o_overflow  out  1  |i_angle| > PI_Q for the last request
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; o_sin=o_cos=0; o_overflow=0; o_complete=1.
//  Reset mid-operation aborts the operation; no partial result reaches the outputs.
//  Start handshake:
//   - Edge with IDLE && i_start: latch i_angle, clear o_complete, go to RED.
//   - i_start while busy is ignored; nothing is queued.
//  States, one cycle each, in order:
//   RED, Y, Y2, Y3, Y5, Y7, T1, T3, T5, T7 (pass=SIN),
//   then the same ten states again (pass=COS), then DONE, then IDLE.
//  Latency: start sampled at edge E; outputs and o_complete=1 update at edge E+21.
//  Holding i_start high gives back-to-back operations, one every 22 cycles.
//  Range reduction (RED), with m = min(|a|, PI_Q):
//   - o_overflow <= (|a| > PI_Q).
//   - SIN: x = (m > HALF_PI) ? PI_Q - m : m; sign_fix = sign(a).
//   - COS: x = (m <= HALF_PI) ? HALF_PI - m : m - HALF_PI; sign_fix = (m > HALF_PI).
//  Datapath: each state issues one multiply; results go to registers.
//   - Y: y = x*K_2PI.  Y2: y2 = y*y.  Y3: y3 = y*y2.  Y5: y5 = y3*y2.  Y7: y7 = y5*y2.
//   - T1: acc <= y*C1.  T3/T5/T7: acc <= qadd(acc, yk*Ck).
//   - Multiply and add chain combinationally within one cycle.
//  Finishing a pass: magnitude = acc[N-2:0]; sign = acc[N-1] ^ sign_fix.
//   - A zero magnitude always gets sign 0 (no negative zero).
//   - SIN result goes to a holding register; o_sin and o_cos both update in DONE.
//  Outputs hold their values until the next DONE or reset.
//  Arithmetic: sign-magnitude truncation as in qmult_SN; products take bits [N-2+Q:Q]; no saturation.
//   - Reduced x <= HALF_PI keeps every intermediate below 2.0.
//  Accuracy: within +/-4 LSB of the ideal value over the full input range.
// STRUCTURE
//  Package/include sincos_pkg.vh holds:
//   - K_2PI=24'h000A2F, C1=24'h001921, C3=24'h800A55, C5=24'h000146, C7=24'h800013
//   - PI_Q=24'h003244, HALF_PI=24'h001922
//   - the state encoding (5-bit)
//  Exactly one qmult_SN and one qadd_SN instance, with operand muxes driven by state.
//  One natural sub-module: sincos_range_reduce (combinational: angle, pass -> x, sign_fix, ovf).
//  FSM, pass bit, y/y2/y3/y5/y7/acc/sin_hold registers live in sincos_seq.
// TESTING
//  1) Angle 0: start -> after 21 cycles sin=0x000000, cos=0x001000 (+/-4); overflow=0.
//  2) Angle 0x000861 (pi/6): sin~0x000800, cos~0x000DDB; o_complete low for exactly 21 cycles.
//  3) Angle 0x801922 (-pi/2): sin~0x801000, cos~0x000000 with sign bit 0.
//  4) Angle 0x002800 (2.5 rad): sin~0x000993, cos~0x800CD1 (checks quadrant sign).
//  5) Angle 0x004000 (4.0 rad): o_overflow=1, sin~0x000000, cos~0x801000 (clamped to pi).
//  6) Pulse i_start at cycle 5 of a run: ignored.
//     Assert i_rst_n=0 at cycle 12: outputs 0, o_complete=1 immediately.
//     Restart after reset: correct result 21 cycles later.

Source files
------------

// File: rtl/sincos_pkg.sv
// Shared constants, state encoding and pass selector for the sequential sin/cos engine.
// Fixed-point constants are sign-magnitude Q12 in a 24-bit word.
package sincos_pkg;

  localparam int SC_N = 24;
  localparam int SC_Q = 12;

  localparam logic [SC_N-1:0] K_2PI   = 24'h000A2F;
  localparam logic [SC_N-1:0] C1      = 24'h001921;
  localparam logic [SC_N-1:0] C3      = 24'h800A55;
  localparam logic [SC_N-1:0] C5      = 24'h000146;
  localparam logic [SC_N-1:0] C7      = 24'h800013;
  localparam logic [SC_N-1:0] PI_Q    = 24'h003244;
  localparam logic [SC_N-1:0] HALF_PI = 24'h001922;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0,
    S_RED  = 5'd1,
    S_Y    = 5'd2,
    S_Y2   = 5'd3,
    S_Y3   = 5'd4,
    S_Y5   = 5'd5,
    S_Y7   = 5'd6,
    S_T1   = 5'd7,
    S_T3   = 5'd8,
    S_T5   = 5'd9,
    S_T7   = 5'd10,
    S_DONE = 5'd11
  } state_t;

  typedef enum logic {
    PASS_SIN = 1'b0,
    PASS_COS = 1'b1
  } pass_t;

endpackage

// File: rtl/qadd_SN.sv
// Sign-magnitude fixed-point adder; unlike signs subtract the smaller magnitude
// from the larger and keep the larger operand's sign. No saturation.
module qadd_SN #(
  parameter int N = 24
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  always_comb begin
    o_sum = '0;
    if (i_a[N-1] == i_b[N-1]) begin
      o_sum[N-2:0] = i_a[N-2:0] + i_b[N-2:0];
      o_sum[N-1]   = i_a[N-1];
    end else if (i_a[N-2:0] > i_b[N-2:0]) begin
      o_sum[N-2:0] = i_a[N-2:0] - i_b[N-2:0];
      o_sum[N-1]   = i_a[N-1];
    end else begin
      o_sum[N-2:0] = i_b[N-2:0] - i_a[N-2:0];
      o_sum[N-1]   = i_b[N-1];
    end
  end

endmodule

// File: rtl/qmult_SN.sv
// Sign-magnitude fixed-point multiplier; the magnitude product is truncated to
// bits [N-2+Q:Q] with no saturation.
module qmult_SN #(
  parameter int Q = 12,
  parameter int N = 24
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_result
);

  logic [2*N-3:0] w_full;

  always_comb begin
    w_full   = i_a[N-2:0] * i_b[N-2:0];
    o_result = {i_a[N-1] ^ i_b[N-1], (N-1)'(w_full >> Q)};
  end

endmodule

// File: rtl/sincos_range_reduce.sv
// Folds an angle in [-pi, pi] (clamped beyond) onto [0, pi/2] for the selected pass
// and reports the sign correction that the polynomial result needs.
module sincos_range_reduce
  import sincos_pkg::*;
#(
  parameter int N = 24
) (
  input  logic [N-1:0] i_angle,
  input  pass_t        i_pass,
  output logic [N-1:0] o_x,
  output logic         o_sign_fix,
  output logic         o_ovf
);

  logic [N-2:0] w_mag;
  logic [N-2:0] w_m;
  logic [N-2:0] w_pi;
  logic [N-2:0] w_hpi;

  always_comb begin
    w_pi       = PI_Q[N-2:0];
    w_hpi      = HALF_PI[N-2:0];
    w_mag      = i_angle[N-2:0];
    o_ovf      = (w_mag > w_pi);
    w_m        = o_ovf ? w_pi : w_mag;
    o_x        = '0;
    o_sign_fix = 1'b0;
    if (i_pass == PASS_SIN) begin
      o_x[N-2:0] = (w_m > w_hpi) ? (w_pi - w_m) : w_m;
      o_sign_fix = i_angle[N-1];
    end else begin
      // cos(m) = sin(pi/2 - m); past pi/2 the same magnitude comes back negative
      o_x[N-2:0] = (w_m <= w_hpi) ? (w_hpi - w_m) : (w_m - w_hpi);
      o_sign_fix = (w_m > w_hpi);
    end
  end

endmodule

// File: rtl/sincos_seq.sv
// Time-multiplexed sin/cos engine: one shared multiplier and adder evaluate a 7th-order
// odd polynomial twice (sin pass, cos pass); start/complete handshake as in qdiv_SN.
module sincos_seq
  import sincos_pkg::*;
#(
  parameter int Q = 12,
  parameter int N = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_angle,
  output logic [N-1:0] o_sin,
  output logic [N-1:0] o_cos,
  output logic         o_complete,
  output logic         o_overflow
);

  state_t       r_state;
  state_t       w_next;
  pass_t        r_pass;
  logic [N-1:0] r_angle;
  logic [N-1:0] r_x;
  logic [N-1:0] r_y;
  logic [N-1:0] r_y2;
  logic [N-1:0] r_y3;
  logic [N-1:0] r_y5;
  logic [N-1:0] r_y7;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_sin_hold;
  logic [N-1:0] r_sin;
  logic [N-1:0] r_cos;
  logic         r_sign_fix;
  logic         r_ovf;

  logic [N-1:0] w_x;
  logic         w_sign_fix;
  logic         w_ovf;
  logic [N-1:0] w_ma;
  logic [N-1:0] w_mb;
  logic [N-1:0] w_prod;
  logic [N-1:0] w_sum;

  // Apply the quadrant sign and suppress negative zero.
  function automatic logic [N-1:0] fix_sign(input logic [N-1:0] v, input logic s);
    logic [N-1:0] r;
    r[N-2:0] = v[N-2:0];
    r[N-1]   = (v[N-2:0] != '0) && (v[N-1] ^ s);
    return r;
  endfunction

  sincos_range_reduce #(.N(N)) u_red (
    .i_angle    (r_angle),
    .i_pass     (r_pass),
    .o_x        (w_x),
    .o_sign_fix (w_sign_fix),
    .o_ovf      (w_ovf)
  );

  qmult_SN #(.Q(Q), .N(N)) u_mul (
    .i_a      (w_ma),
    .i_b      (w_mb),
    .o_result (w_prod)
  );

  qadd_SN #(.N(N)) u_add (
    .i_a   (r_acc),
    .i_b   (w_prod),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pass  <= PASS_SIN;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)
        r_pass <= PASS_SIN;
      else if (r_state == S_T7)
        r_pass <= (r_pass == PASS_SIN) ? PASS_COS : PASS_SIN;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_complete = 1'b1;
        if (i_start) w_next = S_RED;
      end
      S_RED:   w_next = S_Y;
      S_Y:     w_next = S_Y2;
      S_Y2:    w_next = S_Y3;
      S_Y3:    w_next = S_Y5;
      S_Y5:    w_next = S_Y7;
      S_Y7:    w_next = S_T1;
      S_T1:    w_next = S_T3;
      S_T3:    w_next = S_T5;
      S_T5:    w_next = S_T7;
      S_T7:    w_next = (r_pass == PASS_COS) ? S_DONE : S_RED;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ma = r_y;
    w_mb = C1;
    case (r_state)
      S_Y:  begin w_ma = r_x;  w_mb = K_2PI; end
      S_Y2: begin w_ma = r_y;  w_mb = r_y;   end
      S_Y3: begin w_ma = r_y;  w_mb = r_y2;  end
      S_Y5: begin w_ma = r_y3; w_mb = r_y2;  end
      S_Y7: begin w_ma = r_y5; w_mb = r_y2;  end
      S_T1: begin w_ma = r_y;  w_mb = C1;    end
      S_T3: begin w_ma = r_y3; w_mb = C3;    end
      S_T5: begin w_ma = r_y5; w_mb = C5;    end
      S_T7: begin w_ma = r_y7; w_mb = C7;    end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_start)
      r_angle <= i_angle;
    case (r_state)
      S_RED: begin
        r_x        <= w_x;
        r_sign_fix <= w_sign_fix;
      end
      S_Y:        r_y   <= w_prod;
      S_Y2:       r_y2  <= w_prod;
      S_Y3:       r_y3  <= w_prod;
      S_Y5:       r_y5  <= w_prod;
      S_Y7:       r_y7  <= w_prod;
      S_T1:       r_acc <= w_prod;
      S_T3, S_T5: r_acc <= w_sum;
      S_T7: begin
        r_acc <= w_sum;
        if (r_pass == PASS_SIN)
          r_sin_hold <= fix_sign(w_sum, r_sign_fix);
      end
      default: ;
    endcase
  end

  // Visible results only move in DONE, so an aborted run never leaks partial values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sin <= '0;
      r_cos <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == S_RED)
        r_ovf <= w_ovf;
      if (r_state == S_DONE) begin
        r_sin <= r_sin_hold;
        r_cos <= fix_sign(r_acc, r_sign_fix);
      end
    end
  end

  assign o_sin      = r_sin;
  assign o_cos      = r_cos;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_sincos_seq.sv
// Bench for sincos_seq: directed and random angles compared against real-valued
// sin/cos of the clamped angle, plus handshake, latency and reset-abort behaviour.
module tb_sincos_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] angle = 24'h0;
  logic [23:0] o_sin;
  logic [23:0] o_cos;
  logic        o_complete;
  logic        o_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sincos_seq dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_angle    (angle),
    .o_sin      (o_sin),
    .o_cos      (o_cos),
    .o_complete (o_complete),
    .o_overflow (o_overflow)
  );

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic int sm2int(input logic [23:0] v);
    int m;
    m = int'(v[22:0]);
    return v[23] ? -m : m;
  endfunction

  // Angle magnitude in radians, clamped to the Q12 value of pi (12868).
  function automatic real clamp_rad(input logic [23:0] a);
    int m;
    m = int'(a[22:0]);
    if (m > 12868) m = 12868;
    return $itor(m) / 4096.0;
  endfunction

  function automatic int to_q12(input real r);
    return (r >= 0.0) ? $rtoi(r * 4096.0 + 0.5) : -$rtoi(-r * 4096.0 + 0.5);
  endfunction

  function automatic int ideal_sin(input logic [23:0] a);
    real s;
    s = $sin(clamp_rad(a));
    return to_q12(a[23] ? -s : s);
  endfunction

  function automatic int ideal_cos(input logic [23:0] a);
    return to_q12($cos(clamp_rad(a)));
  endfunction

  task automatic check_result(input string tag, input logic [23:0] a);
    chk({tag, "_sin"}, sm2int(o_sin), ideal_sin(a), 4);
    chk({tag, "_cos"}, sm2int(o_cos), ideal_cos(a), 4);
    chk({tag, "_ovf"}, int'(o_overflow), (int'(a[22:0]) > 12868) ? 1 : 0, 0);
    chk({tag, "_sin_nz"}, int'(o_sin == 24'h800000), 0, 0);
    chk({tag, "_cos_nz"}, int'(o_cos == 24'h800000), 0, 0);
  endtask

  // Counts edges until o_complete rises (bounded); optionally pulses i_start mid-run.
  task automatic wait_done(output int cyc, input int pulse_at, input logic [23:0] pulse_angle);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (pulse_at > 0 && cyc == pulse_at) begin
        start = 1'b1;
        angle = pulse_angle;
      end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
        start = 1'b0;
      end
    end while (!o_complete && cyc < 60);
  endtask

  task automatic do_op(input string tag, input logic [23:0] a, input int pulse_at,
                       input logic [23:0] pulse_angle);
    int cyc;
    @(negedge clk);
    angle = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(o_complete), 0, 0);
    wait_done(cyc, pulse_at, pulse_angle);
    chk({tag, "_lat"}, cyc, 21, 0);
    check_result(tag, a);
  endtask

  initial begin
    int cyc;
    logic [23:0] ra;
    logic [23:0] bnd [10];

    #3 rst_n = 1'b0;
    #1;
    chk("rst_sin", sm2int(o_sin), 0, 0);
    chk("rst_cos", sm2int(o_cos), 0, 0);
    chk("rst_ovf", int'(o_overflow), 0, 0);
    chk("rst_cmp", int'(o_complete), 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("zero",   24'h000000, 0, 24'h0);
    do_op("pi6",    24'h000861, 0, 24'h0);
    do_op("mhpi",   24'h801922, 0, 24'h0);
    do_op("q2",     24'h002800, 0, 24'h0);
    do_op("clamp",  24'h004000, 0, 24'h0);

    // Start pulse at cycle 5 must be ignored and nothing queued.
    do_op("ign", 24'h000861, 5, 24'h002800);
    repeat (3) @(posedge clk);
    #1 chk("noqueue", int'(o_complete), 1, 0);

    // Held start: back-to-back operations 22 cycles apart.
    @(negedge clk);
    angle = 24'h801000;
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc, 0, 24'h0);
    chk("b2b1_lat", cyc, 21, 0);
    check_result("b2b1", 24'h801000);
    angle = 24'h804000;
    wait_done(cyc, 0, 24'h0);
    start = 1'b0;
    chk("b2b2_lat", cyc, 22, 0);
    check_result("b2b2", 24'h804000);

    // Reset at cycle 12 aborts the run and clears the outputs at once.
    @(negedge clk);
    angle = 24'h001000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sin", sm2int(o_sin), 0, 0);
    chk("abort_cos", sm2int(o_cos), 0, 0);
    chk("abort_ovf", int'(o_overflow), 0, 0);
    chk("abort_cmp", int'(o_complete), 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("restart", 24'h001000, 0, 24'h0);

    bnd = '{24'h003244, 24'h003245, 24'h803244, 24'h001921, 24'h001922,
            24'h001923, 24'h801923, 24'h7FFFFF, 24'h800000, 24'h000001};
    foreach (bnd[i]) do_op("bnd", bnd[i], 0, 24'h0);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom_range(0, 1) == 1, 23'($urandom_range(0, 14000))};
      do_op("rnd", ra, 0, 24'h0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
